// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer block.
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_fsm.sv
// Control FSM for the countdown timer: state register, status flags and terminal-count pulse.
module countdown_timer_fsm
    import countdown_timer_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   start_i,
    input  logic   load_zero_i,
    input  logic   hold_i,
    input  logic   reload_i,
    input  logic   stop_i,
    input  logic   ack_i,
    input  logic   cnt_one_i,
    output state_e state_o,
    output logic   busy_o,
    output logic   done_o,
    output logic   tc_o
);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   tc_q, tc_d;

    // All state advances on the falling clock edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tc_q    <= tc_d;
        end
    end

    // RUN priority: stop, then hold, then terminal detection.
    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (load_zero_i) begin
                        state_d = ST_DONE;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (!hold_i && cnt_one_i) begin
                    tc_d = 1'b1;
                    if (!reload_i) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable falling-edge down-counter with optional periodic reload and done/ack handshake.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             reload,
    input  logic             stop,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    state_e           state;
    logic             cnt_one;

    assign cnt_one = (count_q == WIDTH'(1));

    countdown_timer_fsm u_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start),
        .load_zero_i (load_val == '0),
        .hold_i      (hold),
        .reload_i    (reload),
        .stop_i      (stop),
        .ack_i       (ack),
        .cnt_one_i   (cnt_one),
        .state_o     (state),
        .busy_o      (busy),
        .done_o      (done),
        .tc_o        (tc)
    );

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    // Datapath mirrors the FSM decisions; a zero load simply lands count at 0.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    reload_d = load_val;
                    count_d  = load_val;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    count_d = '0;
                end else if (hold) begin
                    count_d = count_q;
                end else if (cnt_one) begin
                    count_d = reload ? reload_q : '0;
                end else if (count_q != '0) begin
                    count_d = WIDTH'(count_q - WIDTH'(1));
                end
            end
            ST_DONE: count_d = '0;
            default: count_d = '0;
        endcase
    end

    assign count = count_q;

endmodule
